// File: rtl/fetch_pkg.sv
// fetch_pkg: types and helpers shared by the instruction-fetch stage.
//   fetch_state_e : BOOT -> RUN -> HALT state encoding
//   NOP_INSTR     : word placed into IF/ID when a bubble is inserted
//   addr_ok()     : fetch-address legality (word aligned and inside memory)
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
    localparam logic [31:0] DEF_MEM_BYTES = 32'd256;

    // A fetch address is legal when it is word aligned and lies inside
    // the instruction memory.
    function automatic logic addr_ok(input logic [31:0] addr,
                                     input logic [31:0] mem_bytes);
        return (addr[1:0] == 2'b00) && (addr < mem_bytes);
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline register.
//   clk, rst_n   : clock, synchronous active-low reset
//   i_load       : capture i_instr/i_pc as a valid instruction
//   i_bubble     : replace contents with NOP, valid=0 (wins over i_load)
//   i_instr/i_pc : word and address being fetched this cycle
//   o_instr/o_pc/o_pc4/o_valid : registered IF/ID contents
// With neither control asserted the register holds.
module ifid_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP = NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_bubble,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_pc4;
    logic        r_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instr <= NOP;
            r_pc    <= 32'h0;
            r_pc4   <= 32'h0;
            r_valid <= 1'b0;
        end else if (i_bubble) begin
            // Address fields are left as they were; consumers key off valid.
            r_instr <= NOP;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_pc    <= i_pc;
            r_pc4   <= i_pc + 32'd4;
            r_valid <= 1'b1;
        end
    end

    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the pipelined CPU.
//   clk, rst_n          : clock, synchronous active-low reset
//   stall               : hold PC and IF/ID
//   branch_taken/target : redirect from EX (overrides stall)
//   imem_data           : combinational word for imem_addr
//   imem_addr/enable    : instruction memory address (=PC) / enable (RUN only)
//   ifid_instr/pc/pc4/valid : IF/ID pipeline register
//   fault               : sticky illegal-fetch flag, cleared only by reset
//   fetch_count         : number of valid words written into IF/ID
// Owns PC, the BOOT/RUN/HALT sequencer and the fetch counter; the IF/ID
// register itself is the ifid_reg sub-module.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] MEM_BYTES = DEF_MEM_BYTES,
    parameter logic [31:0] NOP       = NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] imem_data,
    output logic [31:0] imem_addr,
    output logic        imem_enable,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        fault,
    output logic [31:0] fetch_count
);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic         r_fault;
    logic         r_imem_en;
    logic [31:0]  r_count;

    logic [31:0]  w_pc_next4;
    logic         w_seq_end;
    logic         w_tgt_ok;
    logic         w_load;
    logic         w_bubble;

    assign w_pc_next4 = r_pc + 32'd4;
    // Next sequential word falls off the end of memory: this capture is
    // the last one before halting.
    assign w_seq_end  = (w_pc_next4 >= MEM_BYTES);
    assign w_tgt_ok   = addr_ok(branch_target, MEM_BYTES);

    // Branch bubbles the wrong-path word even when stalled; HALT keeps
    // IF/ID empty.
    assign w_load   = (r_state == ST_RUN) && !branch_taken && !stall;
    assign w_bubble = ((r_state == ST_RUN) && branch_taken) || (r_state == ST_HALT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_BOOT;
            r_pc      <= RESET_PC;
            r_fault   <= 1'b0;
            r_imem_en <= 1'b0;
            r_count   <= 32'h0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    // One precharge cycle; an illegal reset vector halts at once.
                    if (addr_ok(RESET_PC, MEM_BYTES)) begin
                        r_state   <= ST_RUN;
                        r_imem_en <= 1'b1;
                    end else begin
                        r_state   <= ST_HALT;
                        r_fault   <= 1'b1;
                        r_imem_en <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (branch_taken) begin
                        if (w_tgt_ok) begin
                            r_pc <= branch_target;
                        end else begin
                            r_state   <= ST_HALT;
                            r_fault   <= 1'b1;
                            r_imem_en <= 1'b0;
                        end
                    end else if (!stall) begin
                        r_count <= r_count + 32'd1;
                        if (w_seq_end) begin
                            r_state   <= ST_HALT;
                            r_fault   <= 1'b1;
                            r_imem_en <= 1'b0;
                        end else begin
                            r_pc <= w_pc_next4;
                        end
                    end
                end
                ST_HALT: begin
                    r_imem_en <= 1'b0;
                end
                default: begin
                    r_state   <= ST_HALT;
                    r_fault   <= 1'b1;
                    r_imem_en <= 1'b0;
                end
            endcase
        end
    end

    ifid_reg #(
        .NOP(NOP)
    ) u_ifid (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_bubble (w_bubble),
        .i_instr  (imem_data),
        .i_pc     (r_pc),
        .o_instr  (ifid_instr),
        .o_pc     (ifid_pc),
        .o_pc4    (ifid_pc4),
        .o_valid  (ifid_valid)
    );

    assign imem_addr   = r_pc;
    assign imem_enable = r_imem_en;
    assign fault       = r_fault;
    assign fetch_count = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_data;
    logic [31:0] imem_addr;
    logic        imem_enable;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        fault;
    logic [31:0] fetch_count;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    // Instruction memory contents (big-endian words, indexed by byte address).
    function automatic logic [31:0] mword(input logic [31:0] a);
        if (a >= 32'd256) return 32'hDEAD_BEEF;
        case (a)
            32'h00:  return 32'hE3A0_1005;
            32'h04:  return 32'hE281_1001;
            32'h08:  return 32'hE081_2002;
            32'h0C:  return 32'hEAFF_FFFE;
            default: return 32'hC0DE_0000 | a;
        endcase
    endfunction

    assign imem_data = mword(imem_addr);

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_data     (imem_data),
        .imem_addr     (imem_addr),
        .imem_enable   (imem_enable),
        .ifid_instr    (ifid_instr),
        .ifid_pc       (ifid_pc),
        .ifid_pc4      (ifid_pc4),
        .ifid_valid    (ifid_valid),
        .fault         (fault),
        .fetch_count   (fetch_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase: 0 = precharge cycle, 1 = fetching, 2 = stopped.
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic        m_valid;
    logic        m_fault;
    logic [31:0] m_cnt;

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (a < 256);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0; m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
            m_valid = 1'b0; m_fault = 1'b0; m_cnt = 32'h0;
        end else if (m_phase == 0) begin
            if (legal(32'h0)) m_phase = 1;
            else begin m_phase = 2; m_fault = 1'b1; end
        end else if (m_phase == 1) begin
            if (branch_taken) begin
                m_instr = 32'h0; m_valid = 1'b0;
                if (legal(branch_target)) m_pc = branch_target;
                else begin m_phase = 2; m_fault = 1'b1; end
            end else if (!stall) begin
                m_instr = mword(m_pc); m_ipc = m_pc; m_valid = 1'b1;
                m_cnt = m_cnt + 1;
                if (m_pc + 4 >= 256) begin m_phase = 2; m_fault = 1'b1; end
                else m_pc = m_pc + 4;
            end
        end else begin
            m_instr = 32'h0; m_valid = 1'b0;
        end
    end

    // Single compare process against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("imem_addr",   imem_addr,   m_pc);
            chk("imem_enable", {31'b0, imem_enable}, {31'b0, m_phase == 1});
            chk("ifid_instr",  ifid_instr,  m_instr);
            chk("ifid_valid",  {31'b0, ifid_valid}, {31'b0, m_valid});
            chk("fault",       {31'b0, fault}, {31'b0, m_fault});
            chk("fetch_count", fetch_count, m_cnt);
            if (m_valid) begin
                chk("ifid_pc",  ifid_pc,  m_ipc);
                chk("ifid_pc4", ifid_pc4, m_ipc + 32'd4);
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"},  imem_addr, 32'h0);
        chk({tag, "_en"},    {31'b0, imem_enable}, 32'h0);
        chk({tag, "_instr"}, ifid_instr, 32'h0);
        chk({tag, "_pc"},    ifid_pc, 32'h0);
        chk({tag, "_pc4"},   ifid_pc4, 32'h0);
        chk({tag, "_valid"}, {31'b0, ifid_valid}, 32'h0);
        chk({tag, "_fault"}, {31'b0, fault}, 32'h0);
        chk({tag, "_cnt"},   fetch_count, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk_reset_vals("rst0");

        // Free run: BOOT edge, then four captures.
        rst_n = 1'b1;
        @(negedge clk);
        chk("boot_valid", {31'b0, ifid_valid}, 32'h0);
        chk("boot_en", {31'b0, imem_enable}, 32'h1);
        @(negedge clk);
        chk("first_instr", ifid_instr, 32'hE3A0_1005);
        chk("first_pc", ifid_pc, 32'h0);
        repeat (3) @(negedge clk);
        chk("fourth_instr", ifid_instr, 32'hEAFF_FFFE);
        chk("fourth_pc", ifid_pc, 32'h0C);
        chk("fourth_pc4", ifid_pc4, 32'h10);
        chk("fourth_cnt", fetch_count, 32'd4);

        // Stall at pc=8.
        rst_n = 1'b0; @(negedge clk);
        rst_n = 1'b1; repeat (3) @(negedge clk);
        stall = 1'b1; repeat (3) @(negedge clk);
        chk("stall_ifid_pc", ifid_pc, 32'h4);
        chk("stall_pc", imem_addr, 32'h8);
        chk("stall_cnt", fetch_count, 32'd2);
        stall = 1'b0; @(negedge clk);
        chk("unstall_pc", ifid_pc, 32'h8);
        chk("unstall_instr", ifid_instr, 32'hE081_2002);

        // Branch to 0x20 at pc=0x0C with simultaneous stall.
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h20;
        @(negedge clk);
        stall = 1'b0; branch_taken = 1'b0;
        chk("br_bubble", {31'b0, ifid_valid}, 32'h0);
        chk("br_pc", imem_addr, 32'h20);
        @(negedge clk);
        chk("br_tgt_pc", ifid_pc, 32'h20);
        chk("br_tgt_instr", ifid_instr, 32'hC0DE_0020);
        chk("br_cnt", fetch_count, 32'd4);

        // Misaligned branch target halts with fault.
        branch_taken = 1'b1; branch_target = 32'h22;
        @(negedge clk);
        branch_taken = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("halt_fault", {31'b0, fault}, 32'h1);
            chk("halt_en", {31'b0, imem_enable}, 32'h0);
            chk("halt_valid", {31'b0, ifid_valid}, 32'h0);
            chk("halt_pc", imem_addr, 32'h24);
            @(negedge clk);
        end
        rst_n = 1'b0; @(negedge clk);
        chk_reset_vals("rst_halt");

        // Sequential run to end of memory.
        rst_n = 1'b1;
        for (int i = 0; i < 100 && !fault; i++) @(negedge clk);
        chk("end_timeout", {31'b0, fault}, 32'h1);
        chk("end_pc", ifid_pc, 32'hFC);
        chk("end_valid", {31'b0, ifid_valid}, 32'h1);
        chk("end_instr", ifid_instr, 32'hC0DE_00FC);
        chk("end_hold_pc", imem_addr, 32'hFC);
        chk("end_cnt", fetch_count, 32'd64);
        @(negedge clk);
        chk("end_bubble", {31'b0, ifid_valid}, 32'h0);
        chk("end_cnt_frozen", fetch_count, 32'd64);

        // Reset wins over stall + branch in RUN.
        rst_n = 1'b0; @(negedge clk);
        rst_n = 1'b1; repeat (3) @(negedge clk);
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40; rst_n = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst_mid");
        stall = 1'b0; branch_taken = 1'b0; rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_pc", ifid_pc, 32'h4);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined RISC CPU, directly upstream of the 256×8 instruction memory. It owns the program counter, drives the memory address/enable, and captures the returned 32-bit big-endian word into the IF/ID pipeline register with stall, flush/branch-redirect and fault handling. It also keeps a retired-fetch counter for debug.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- MEM_BYTES, 256, instruction memory size in bytes; fetches at or beyond this fault
- NOP, 32'h0000_0000, instruction word inserted into IF/ID on bubble/flush

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk
- stall  in  1  hazard unit hold; PC and IF/ID keep their values
- branch_taken  in  1  redirect request from EX stage
- branch_target  in  32  redirect byte address
- imem_data  in  32  word from instruction memory, valid combinationally for current imem_addr
- imem_addr  out  32  equals PC
- imem_enable  out  1  high only in state RUN
- ifid_instr  out  32  registered instruction
- ifid_pc  out  32  address of ifid_instr
- ifid_pc4  out  32  ifid_pc + 4
- ifid_valid  out  1  ifid_instr is a real instruction
- fault  out  1  sticky misaligned/out-of-range fetch
- fetch_count  out  32  number of instructions written into IF/ID with valid=1

## Operation
- States: BOOT, RUN, HALT.
- Reset (rst_n=0 at edge): state=BOOT, pc=RESET_PC, ifid_instr=NOP, ifid_pc=0, ifid_pc4=0, ifid_valid=0, fault=0, fetch_count=0, imem_enable=0.
- BOOT: exactly one cycle (memory precharge window), no capture; next RUN. If RESET_PC[1:0]≠0 or RESET_PC≥MEM_BYTES, next HALT with fault=1.
- RUN, per edge, priority highest first:
  - branch_taken: pc←branch_target; IF/ID←bubble (NOP, valid 0). Overrides stall. If branch_target[1:0]≠0 or branch_target≥MEM_BYTES: pc unchanged, fault←1, state←HALT.
  - stall: pc, IF/ID, fetch_count hold.
  - normal: ifid_instr←imem_data, ifid_pc←pc, ifid_pc4←pc+4, ifid_valid←1, fetch_count+1, pc←pc+4. If pc+4≥MEM_BYTES: capture still occurs, then pc holds, fault←1, state←HALT.
- HALT: imem_enable=0; IF/ID held as bubble; pc, fetch_count frozen; fault stays 1; exit only by reset.
- Arithmetic: pc+4 and fetch_count are 32-bit modulo; fetch_count wraps 32'hFFFF_FFFF→0.

## Timing
- imem_addr is combinational from pc register; imem_data sampled same cycle (zero-wait memory).
- Fetch latency: word at address A appears on ifid_instr one edge after pc=A in RUN.
- Branch penalty: 1 bubble from this stage (the captured wrong-path word is discarded); target instruction in IF/ID two edges after branch_taken edge.
- First valid ifid output: second rising edge after rst_n rises (BOOT edge, then first capture).
- Reset mid-operation: takes effect at the next edge regardless of state, stall or branch.
- stall released: capture resumes same edge stall is low; no word lost or duplicated.

## Structure
- Shared package fetch_pkg: state enum (BOOT, RUN, HALT), NOP constant, alignment-check function (addr[1:0]==0 and addr<MEM_BYTES).
- One sub-module: ifid_reg (instr/pc/pc4/valid register with load, hold, bubble controls, synchronous active-low reset). PC, FSM and counter live in fetch_stage.

## Test plan
- Reset then free-run with memory words 0xE3A01005, 0xE2811001, 0xE0812002, 0xEAFFFFFE at 0,4,8,12 -> ifid_instr follows that order, ifid_pc 0,4,8,12, fetch_count 4 after fourth capture.
- stall high for 3 cycles while pc=8 -> ifid_pc stays 4, pc stays 8, fetch_count unchanged; after release next ifid_pc=8.
- branch_taken with target 0x20 at pc=0x0C, simultaneous stall -> ifid_valid=0 next cycle, pc=0x20, then ifid_pc=0x20 valid.
- branch_target 0x22 -> fault=1, state HALT, imem_enable=0, ifid_valid=0, persists 10 cycles until rst_n=0 clears all outputs to reset values.
- Sequential fetch up to 0xFC with MEM_BYTES=256 -> word at 0xFC captured valid, then fault=1, pc held at 0xFC.
- rst_n asserted during stall+branch in RUN -> next edge pc=RESET_PC, state BOOT, all outputs at reset values.
